inta_sequencer: RTL and testbench
=================================

Name: inta_sequencer

Overview:
- CPU-side initiator of the interrupt-acknowledge protocol that the PIC answers.
- Watches the PIC's INT output and, when the core has interrupts enabled, drives the INTA pulse train.
- Samples the PIC's data-bus byte on each pulse, then presents the vector (8086 mode) or the CALL target (8080 mode) to the core over a valid/ready handshake.
- Sits between the PIC pins and the CPU core's interrupt entry logic.

Parameters:
- PULSE_CYCLES, 2, clocks INTA is held low per pulse (legal range 1..255).
- GAP_CYCLES, 2, clocks INTA is held high between consecutive pulses (legal range 1..255).
- CALL_OPCODE, 8'hCD, expected first byte in 8080 mode.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- INT  in  1  interrupt request from the PIC; asynchronous, level.
- D  in  8  PIC data bus, valid while INTA is low.
- mode_8086  in  1  1 = 2-pulse 8086 sequence, 0 = 3-pulse 8080 sequence.
- int_enable  in  1  core interrupt-enable flag.
- vec_ready  in  1  core accepts the result.
- INTA  out  1  active-low acknowledge to the PIC; registered.
- number_of_ack  out  2  count of INTA pulses completed in the current sequence.
- busy  out  1  high from the start of a sequence until the handshake completes.
- vec_valid  out  1  result available.
- vector  out  8  8086: byte of pulse 2. 8080: byte of pulse 2 (low address).
- call_addr  out  16  8080: {byte3, byte2}. 8086: 16'h0000.
- opcode_err  out  1  8080 only: byte1 != CALL_OPCODE. Valid with vec_valid.

Behaviour:
- Reset (async, rst_n=0):
  - INTA=1; vec_valid=0; busy=0; number_of_ack=0.
  - vector=0; call_addr=0; opcode_err=0.
  - Sync flops cleared; FSM in IDLE.
  - Reset mid-sequence releases INTA high immediately, with no completion.
- INT passes a 2-flop synchronizer (int_s). INT rising before edge 0 gives int_s=1 after edge 1.
- States: IDLE, PULSE, GAP, DONE. A down-counter times PULSE and GAP. A 2-bit index k counts pulses.
- IDLE:
  - Start when int_s & int_enable.
  - On the start edge: mode_8086 latched into mode_q (later changes ignored), INTA<=0, busy<=1, k<=0, state<=PULSE.
  - INTA therefore goes low after the third rising edge following INT setup.
- PULSE:
  - INTA held low exactly PULSE_CYCLES clocks.
  - On the edge ending the last low clock, D is captured into byte register k, INTA<=1, and number_of_ack<=k+1.
  - If k+1 < N (N=2 if mode_q, else 3): state<=GAP, k<=k+1.
  - Otherwise: state<=DONE, and on the same edge vector, call_addr, opcode_err and vec_valid<=1 are loaded.
- GAP: INTA high exactly GAP_CYCLES clocks, then INTA<=0 and state<=PULSE.
- DONE:
  - vec_valid held, with outputs stable, until a clock with vec_ready=1.
  - On that edge: vec_valid<=0, busy<=0, number_of_ack<=0, state<=IDLE.
  - vec_ready while vec_valid=0 is ignored.
- The earliest restart is the edge after returning to IDLE, and only if int_s is still high.
- INT deassertion or int_enable=0 after the sequence starts does not abort it; the full N pulses are always issued.
- int_enable=0 in IDLE blocks the start indefinitely; INT is not latched.
- 8086 result: byte1 is discarded; vector=byte2; call_addr=0; opcode_err=0.
- 8080 result: opcode_err=(byte1!=CALL_OPCODE); vector=byte2; call_addr={byte3, byte2}.
- The result is delivered even when opcode_err=1.
- INTA never glitches: it only changes on clock edges, and it is high in IDLE, GAP and DONE.

Test Plan:
- Reset mid-PULSE (8086 mode): assert rst_n=0 while INTA=0 -> INTA=1 immediately, all outputs at reset values, IDLE after release.
- 8086 happy path (P=2, G=2): INT=1, int_enable=1, D=8'h4B on pulse 2 -> INTA low 2 clocks, high 2, low 2 starting 3 edges after INT. Then vec_valid=1 with vector=8'h4B and call_addr=0; cleared on the first vec_ready clock.
- 8080 path: bytes CD, 20, 03 on pulses 1..3 -> 3 pulses, number_of_ack 1,2,3 -> call_addr=16'h0320, vector=8'h20, opcode_err=0. First byte 8'hC3 instead -> opcode_err=1.
- Gating and back-pressure: INT=1 with int_enable=0 for 50 clocks -> INTA stays 1. Enable, complete the sequence, hold vec_ready=0 for 10 clocks -> vec_valid and outputs stable, no new INTA even with INT high.
- INT drop and mode change mid-sequence: deassert INT and toggle mode_8086 after pulse 1 -> remaining pulses still issued per the latched mode, result delivered; no restart while INT is low.

Source files
------------

// File: rtl/inta_sequencer.sv
// inta_sequencer: issues the INTA pulse train for a PIC interrupt request, captures the
// bytes the PIC drives on D, and hands the vector / CALL target to the core.
module inta_sequencer #(
   parameter int unsigned PULSE_CYCLES = 2,
   parameter int unsigned GAP_CYCLES   = 2,
   parameter logic [7:0]  CALL_OPCODE  = 8'hCD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        INT,
   input  logic [7:0]  D,
   input  logic        mode_8086,
   input  logic        int_enable,
   input  logic        vec_ready,
   output logic        INTA,
   output logic [1:0]  number_of_ack,
   output logic        busy,
   output logic        vec_valid,
   output logic [7:0]  vector,
   output logic [15:0] call_addr,
   output logic        opcode_err
);
   typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;
   localparam logic [7:0] P_LOAD = 8'(PULSE_CYCLES - 1);
   localparam logic [7:0] G_LOAD = 8'(GAP_CYCLES - 1);
   state_t      r_state, w_next;
   logic        r_int_meta, r_int_s, r_mode, r_inta, r_busy, r_valid, r_err;
   logic [7:0]  r_cnt, r_b0, r_b1, r_vector;
   logic [1:0]  r_k, r_nack;
   logic [15:0] r_call;
   logic        w_start, w_pulse_end, w_gap_end, w_ack, w_last;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_int_meta <= 1'b0;
         r_int_s    <= 1'b0;
         r_mode     <= 1'b0;
         r_inta     <= 1'b1;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= 8'd0;
         r_b0       <= 8'd0;
         r_b1       <= 8'd0;
         r_vector   <= 8'd0;
         r_k        <= 2'd0;
         r_nack     <= 2'd0;
         r_call     <= 16'd0;
      end else begin
         r_int_meta <= INT;
         r_int_s    <= r_int_meta;
         r_state    <= w_next;
         r_cnt      <= (w_start || w_gap_end) ? P_LOAD :
                       (w_pulse_end && !w_last) ? G_LOAD :
                       (r_cnt != 8'd0) ? r_cnt - 8'd1 : r_cnt;
         r_inta     <= (w_start || w_gap_end) ? 1'b0 : w_pulse_end ? 1'b1 : r_inta;
         if (w_start) begin
            r_mode <= mode_8086;
            r_k    <= 2'd0;
            r_busy <= 1'b1;
         end
         if (w_pulse_end) begin
            r_nack <= r_k + 2'd1;
            if (r_k == 2'd0) r_b0 <= D;
            if (r_k == 2'd1) r_b1 <= D;
            if (!w_last) r_k <= r_k + 2'd1;
            else begin
               // the final byte is still on D, so the result is assembled on the capture edge
               r_valid  <= 1'b1;
               r_vector <= r_mode ? D : r_b1;
               r_call   <= r_mode ? 16'h0000 : {D, r_b1};
               r_err    <= !r_mode && (r_b0 != CALL_OPCODE);
            end
         end
         if (w_ack) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_nack  <= 2'd0;
         end
      end
   end
   always_comb begin
      w_last      = r_mode ? (r_k == 2'd1) : (r_k == 2'd2);
      w_start     = (r_state == IDLE) && r_int_s && int_enable;
      w_pulse_end = (r_state == PULSE) && (r_cnt == 8'd0);
      w_gap_end   = (r_state == GAP) && (r_cnt == 8'd0);
      w_ack       = (r_state == DONE) && vec_ready;
      w_next      = w_start ? PULSE :
                    w_pulse_end ? (w_last ? DONE : GAP) :
                    w_gap_end ? PULSE :
                    w_ack ? IDLE : r_state;
   end
   always_comb begin
      INTA          = r_inta;
      number_of_ack = r_nack;
      busy          = r_busy;
      vec_valid     = r_valid;
      vector        = r_vector;
      call_addr     = r_call;
      opcode_err    = r_err;
   end
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: randomized INTA sequences with a PIC byte model, a pulse-timing
// checker and a result scoreboard fed by the stimulus.
module tb_inta_sequencer;
   localparam int P = 2;
   localparam int G = 2;
   localparam logic [7:0] CALL = 8'hCD;
   typedef struct {logic [7:0] v; logic [15:0] c; logic e;} exp_t;
   logic        clk, rst_n, INT, mode_8086, int_enable, vec_ready;
   logic [7:0]  D;
   logic        INTA, busy, vec_valid, opcode_err;
   logic [1:0]  number_of_ack;
   logic [7:0]  vector;
   logic [15:0] call_addr;
   int          checks = 0, errors = 0;
   exp_t        exp_q[$];
   exp_t        exp_cur;
   logic [7:0]  cur_bytes[3];
   int          pidx, lo, hi;
   logic        prev_inta, pv;

   inta_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .CALL_OPCODE(CALL)) dut (
      .clk(clk), .rst_n(rst_n), .INT(INT), .D(D), .mode_8086(mode_8086),
      .int_enable(int_enable), .vec_ready(vec_ready), .INTA(INTA),
      .number_of_ack(number_of_ack), .busy(busy), .vec_valid(vec_valid),
      .vector(vector), .call_addr(call_addr), .opcode_err(opcode_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", n, a, e, $time);
      end
   endtask

   // PIC model: serves one byte per pulse and times every pulse and gap
   always @(negedge clk) begin
      if (!rst_n) begin
         pidx = 0; lo = 0; hi = 0; prev_inta = 1'b1; D = 8'h00;
      end else begin
         if (!INTA) begin
            if (prev_inta) begin
               if (pidx > 0) chk("gap_len", hi, G);
               D = cur_bytes[pidx % 3];
               lo = 0;
            end
            lo++;
         end else begin
            if (!busy) begin
               pidx = 0;
               chk("idle_inta", INTA, 1);
            end
            if (!prev_inta) begin
               chk("pulse_len", lo, P);
               pidx++;
               chk("nack", number_of_ack, pidx);
               hi = 0;
            end
            hi++;
            D = 8'($urandom);
         end
         prev_inta = INTA;
      end
   end

   // scoreboard monitor: result must match and stay stable while valid
   always @(negedge clk) begin
      if (!rst_n) pv = 1'b0;
      else begin
         if (vec_valid && !pv) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else exp_cur = exp_q.pop_front();
         end
         if (vec_valid) begin
            chk("vector", vector, exp_cur.v);
            chk("call_addr", call_addr, exp_cur.c);
            chk("opcode_err", opcode_err, exp_cur.e);
            chk("inta_in_done", INTA, 1);
         end
         pv = vec_valid;
      end
   end

   task automatic do_seq(input logic m, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int hold, input logic perturb,
                         input logic keep_int, input int lat);
      int t;
      exp_t x;
      cur_bytes[0] = b0; cur_bytes[1] = b1; cur_bytes[2] = b2;
      x.v = b1;
      x.c = m ? 16'h0000 : {b2, b1};
      x.e = !m && (b0 != CALL);
      exp_q.push_back(x);
      mode_8086 = m; int_enable = 1'b1; INT = 1'b1;
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         chk("pre_start", INTA, 1);
      end
      @(negedge clk);
      chk("start", INTA, 0);
      chk("busy", busy, 1);
      t = 0;
      while (number_of_ack == 2'd0 && t < 100) begin @(negedge clk); t++; end
      chk("first_ack", number_of_ack, 1);
      if (!keep_int) INT = 1'b0;
      if (perturb) begin
         mode_8086 = !m;
         int_enable = 1'($urandom);
      end
      t = 0;
      while (!vec_valid && t < 200) begin
         vec_ready = 1'($urandom);
         @(negedge clk);
         t++;
      end
      vec_ready = 1'b0;
      chk("valid", vec_valid, 1);
      chk("nack_done", number_of_ack, m ? 2 : 3);
      repeat (hold) @(negedge clk);
      if (keep_int) begin
         INT = 1'b0;
         repeat (3) @(negedge clk);
      end
      chk("hold_valid", vec_valid, 1);
      vec_ready = 1'b1;
      @(negedge clk);
      vec_ready = 1'b0;
      chk("ack_valid", vec_valid, 0);
      chk("ack_busy", busy, 0);
      chk("ack_nack", number_of_ack, 0);
      repeat (3) begin
         @(negedge clk);
         chk("no_restart", INTA, 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      rst_n = 1'b0; INT = 1'b0; mode_8086 = 1'b1; int_enable = 1'b0; vec_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_inta", INTA, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", vec_valid, 0);
      chk("rst_nack", number_of_ack, 0);
      chk("rst_vector", vector, 0);
      chk("rst_call", call_addr, 0);
      chk("rst_err", opcode_err, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      // reset in the middle of the first pulse
      mode_8086 = 1'b1; int_enable = 1'b1; INT = 1'b1;
      t = 0;
      while (INTA && t < 20) begin @(negedge clk); t++; end
      chk("midrst_low", INTA, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_inta", INTA, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", vec_valid, 0);
      chk("midrst_nack", number_of_ack, 0);
      INT = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_inta", INTA, 1);
         chk("post_rst_busy", busy, 0);
      end
      do_seq(1'b1, 8'h12, 8'h4B, 8'h00, 2, 1'b0, 1'b0, 3);
      do_seq(1'b0, 8'hCD, 8'h20, 8'h03, 1, 1'b0, 1'b0, 3);
      do_seq(1'b0, 8'hC3, 8'h20, 8'h03, 0, 1'b0, 1'b0, 3);
      // gated request, then back-pressure with INT held high
      INT = 1'b1; int_enable = 1'b0;
      repeat (50) begin
         @(negedge clk);
         chk("gated", INTA, 1);
      end
      do_seq(1'b1, 8'h77, 8'hA5, 8'h5A, 10, 1'b0, 1'b1, 1);
      do_seq(1'b0, 8'hCD, 8'h11, 8'h22, 1, 1'b1, 1'b0, 3);
      do_seq(1'b1, 8'h33, 8'h44, 8'h55, 1, 1'b1, 1'b0, 3);
      for (int i = 0; i < 25; i++)
         do_seq(1'($urandom), ($urandom % 2) ? CALL : 8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom % 6), 1'($urandom), 1'b0, 3);
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
